alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- sequencing controller in front of a shared combinational ALU.
//
// Accepts one operation at a time. It decodes the main-control operation class
// and the R-type function field into a 4-bit ALU control code, presents the
// registered operands to the external ALU for one cycle, captures the result,
// and holds it on a valid/ready response port until the consumer takes it.
//
// Build option: define ALU_SEQ_MUL_EN to run multiplies (code 1100) as a
// DATA_W-cycle shift-add sequence inside this block instead of on the shared
// ALU. Without the macro the multiply datapath is not built, and multiplies
// pass through EXEC like any other operation.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake (ready only in IDLE)
//   funct_i, aluop_i             R-type function field, operation class
//   src1_i, src2_i               operands
//   alu_ctrl_o                   ALU control code (non-zero only in EXEC)
//   alu_src1_o, alu_src2_o       operands to the ALU (non-zero only in EXEC)
//   alu_result_i                 combinational ALU result
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_data_o                   result
//   busy_o                       high whenever the FSM is not in IDLE
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for req_valid_i; req_ready_o high
// EXEC  | operands and code driven to the ALU; result captured this cycle
// MUL   | shift-add multiply, one iteration per cycle (ALU_SEQ_MUL_EN only)
// RESP  | rsp_valid_o high, rsp_data_o held until rsp_ready_i

module alu_seq_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [5:0]        funct_i,
   input  logic [3:0]        aluop_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   output logic [3:0]        alu_ctrl_o,
   output logic [DATA_W-1:0] alu_src1_o,
   output logic [DATA_W-1:0] alu_src2_o,
   input  logic [DATA_W-1:0] alu_result_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              busy_o
);

   localparam logic [3:0] CODE_MUL = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
`ifdef ALU_SEQ_MUL_EN
      MUL  = 2'd2,
`endif
      RESP = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] dec_code;

   always_comb begin
      dec_code = 4'b0000;
      case (aluop_i)
         4'b0010: begin
            case (funct_i)
               6'b100001: dec_code = 4'b0010;
               6'b100011: dec_code = 4'b0110;
               6'b100101: dec_code = 4'b0001;
               6'b100100: dec_code = 4'b0000;
               6'b101010: dec_code = 4'b0111;
               6'b000011: dec_code = 4'b1101;
               6'b000111: dec_code = 4'b0011;
               6'b011000: dec_code = 4'b1100;
               default:   dec_code = 4'b0000;
            endcase
         end
         4'b0101: dec_code = 4'b1110;
         4'b0100: dec_code = 4'b1000;
         4'b0011: dec_code = 4'b0100;
         4'b0001: dec_code = 4'b1010;
         4'b0111: dec_code = 4'b0101;
         4'b0110: dec_code = 4'b1001;
         default: dec_code = 4'b0000;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   localparam int CNT_W = $clog2(DATA_W) + 1;

   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc_sum;

   // Only the low DATA_W bits are kept, so the product is sign-agnostic.
   assign acc_sum = mplier[0] ? (acc + mcand) : acc;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         req_ready_o <= 1'b1;
         busy_o      <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         alu_ctrl_o  <= 4'b0000;
         alu_src1_o  <= '0;
         alu_src2_o  <= '0;
`ifdef ALU_SEQ_MUL_EN
         cnt         <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  req_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                  if (dec_code == CODE_MUL) begin
                     state  <= MUL;
                     acc    <= '0;
                     mcand  <= src1_i;
                     mplier <= src2_i;
                     cnt    <= CNT_W'(DATA_W);
                  end else
`endif
                  begin
                     state      <= EXEC;
                     alu_ctrl_o <= dec_code;
                     alu_src1_o <= src1_i;
                     alu_src2_o <= src2_i;
                  end
               end
            end

            EXEC: begin
               state       <= RESP;
               rsp_valid_o <= 1'b1;
               rsp_data_o  <= alu_result_i;
               alu_ctrl_o  <= 4'b0000;
               alu_src1_o  <= '0;
               alu_src2_o  <= '0;
            end

`ifdef ALU_SEQ_MUL_EN
            MUL: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CNT_W'(1);
               // Terminal count: cnt == 1 is the DATA_W-th iteration.
               if (cnt == CNT_W'(1)) begin
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= acc_sum;
               end
            end
`endif

            RESP: begin
               // Returning to IDLE here means req_valid_i on this same edge
               // is not seen as an accept; the next edge is the earliest.
               if (rsp_ready_i) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
               end
            end

            default: begin
               state       <= IDLE;
               rsp_valid_o <= 1'b0;
               req_ready_o <= 1'b1;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

   localparam int DW = 32;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_ITER = 1'b1;
`else
   localparam bit MUL_ITER = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [5:0]    funct_i = '0;
   logic [3:0]    aluop_i = '0;
   logic [DW-1:0] src1_i = '0;
   logic [DW-1:0] src2_i = '0;
   logic [3:0]    alu_ctrl_o;
   logic [DW-1:0] alu_src1_o;
   logic [DW-1:0] alu_src2_o;
   logic [DW-1:0] alu_result_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b0;
   logic [DW-1:0] rsp_data_o;
   logic          busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.DATA_W(DW)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .funct_i     (funct_i),
      .aluop_i     (aluop_i),
      .src1_i      (src1_i),
      .src2_i      (src2_i),
      .alu_ctrl_o  (alu_ctrl_o),
      .alu_src1_o  (alu_src1_o),
      .alu_src2_o  (alu_src2_o),
      .alu_result_i(alu_result_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .busy_o      (busy_o)
   );

   // Behavioural ALU: what each control code computes.
   function automatic logic [DW-1:0] alu_fn(logic [3:0] c, logic [DW-1:0] a, logic [DW-1:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1101: return $signed(b) >>> a[4:0];
         4'b0011: return b << a[4:0];
         4'b1100: return a * b;
         4'b1110: return a ^ b;
         4'b1000: return ~(a | b);
         4'b0100: return {b[15:0], 16'h0000};
         4'b1010: return a + b;
         4'b0101: return a - b;
         4'b1001: return a | b;
         default: return '0;
      endcase
   endfunction

   always_comb alu_result_i = alu_fn(alu_ctrl_o, alu_src1_o, alu_src2_o);

   // Decode reference as lookup tables.
   localparam logic [5:0] RFN [8] = '{6'b100001, 6'b100011, 6'b100101, 6'b100100,
                                      6'b101010, 6'b000011, 6'b000111, 6'b011000};
   localparam logic [3:0] RFC [8] = '{4'b0010, 4'b0110, 4'b0001, 4'b0000,
                                      4'b0111, 4'b1101, 4'b0011, 4'b1100};
   localparam logic [3:0] RAO [6] = '{4'b0101, 4'b0100, 4'b0011, 4'b0001, 4'b0111, 4'b0110};
   localparam logic [3:0] RAC [6] = '{4'b1110, 4'b1000, 4'b0100, 4'b1010, 4'b0101, 4'b1001};

   function automatic logic [3:0] ref_decode(logic [3:0] op, logic [5:0] fn);
      logic [3:0] r = 4'b0000;
      if (op == 4'b0010) begin
         for (int i = 0; i < 8; i++) if (fn == RFN[i]) r = RFC[i];
      end else begin
         for (int i = 0; i < 6; i++) if (op == RAO[i]) r = RAC[i];
      end
      return r;
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_clear(string tag);
      chk({tag, "_ready"}, req_ready_o, 1);
      chk({tag, "_busy"},  busy_o, 0);
      chk({tag, "_valid"}, rsp_valid_o, 0);
      chk({tag, "_ctrl"},  alu_ctrl_o, 0);
      chk({tag, "_src1"},  alu_src1_o, 0);
      chk({tag, "_src2"},  alu_src2_o, 0);
   endtask

   // Issue one operation and drive it through to the response handshake.
   // hold: cycles of rsp_ready_i low once valid; pulse: req_valid_i pulse
   // during the hold; req_at_hs: req_valid_i high on the handshake edge.
   task automatic run_op(logic [3:0] op, logic [5:0] fn, logic [DW-1:0] a, logic [DW-1:0] b,
                         int hold, bit pulse, bit req_at_hs);
      logic [3:0]    code = ref_decode(op, fn);
      bit            iter = MUL_ITER && (code == 4'b1100);
      logic [DW-1:0] exp  = iter ? DW'(a * b) : alu_fn(code, a, b);
      int            exp_lat = iter ? DW + 1 : 2;
      int            n = 0;

      @(negedge clk);
      chk("ready_before", req_ready_o, 1);
      req_valid_i = 1'b1; aluop_i = op; funct_i = fn; src1_i = a; src2_i = b;
      @(posedge clk); #1;
      req_valid_i = 1'b0; src1_i = $urandom; src2_i = $urandom;
      aluop_i = 4'($urandom); funct_i = 6'($urandom);

      // n counts rising edges after the accept up to the one that samples valid.
      while (n < 100) begin
         @(negedge clk); n++;
         if (rsp_valid_o) break;
         if (n == 1) begin
            chk("busy_run", busy_o, 1);
            chk("ready_run", req_ready_o, 0);
            if (!iter) begin
               chk("exec_ctrl", alu_ctrl_o, code);
               chk("exec_src1", alu_src1_o, a);
               chk("exec_src2", alu_src2_o, b);
            end
         end
         if (iter) chk("mul_ctrl_zero", alu_ctrl_o, 0);
      end
      chk("latency", n, exp_lat);
      chk("rsp_data", rsp_data_o, exp);
      chk("resp_ctrl_zero", alu_ctrl_o, 0);

      for (int i = 0; i < hold; i++) begin
         if (pulse && i == 1) begin
            req_valid_i = 1'b1; aluop_i = 4'b0010; funct_i = 6'b100001;
         end
         @(posedge clk); #1;
         req_valid_i = 1'b0;
         @(negedge clk);
         chk("hold_valid", rsp_valid_o, 1);
         chk("hold_data", rsp_data_o, exp);
         chk("hold_ready", req_ready_o, 0);
      end

      rsp_ready_i = 1'b1;
      if (req_at_hs) begin
         req_valid_i = 1'b1; aluop_i = 4'b0110; funct_i = '0;
      end
      @(posedge clk); #1;
      rsp_ready_i = 1'b0;
      @(negedge clk);
      chk("hs_valid", rsp_valid_o, 0);
      chk("hs_ready", req_ready_o, 1);
      chk("hs_busy", busy_o, 0);
      req_valid_i = 1'b0;
   endtask

   task automatic reset_mid(logic [3:0] op, logic [5:0] fn, logic [DW-1:0] a, logic [DW-1:0] b,
                            int wait_cyc);
      @(negedge clk);
      req_valid_i = 1'b1; aluop_i = op; funct_i = fn; src1_i = a; src2_i = b;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      for (int i = 0; i < wait_cyc; i++) @(negedge clk);
      chk("pre_rst_busy", busy_o, 1);
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      check_idle_clear("mid_rst");
      chk("mid_rst_data", rsp_data_o, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check_idle_clear("reset");
      chk("reset_data", rsp_data_o, 0);

      // addu 5 + 7
      run_op(4'b0010, 6'b100001, 32'd5, 32'd7, 0, 1'b0, 1'b0);
      // ori 0x00F0 | 0x000F
      run_op(4'b0110, 6'b000000, 32'h0000_00F0, 32'h0000_000F, 0, 1'b0, 1'b1);
      // multiply 3 x 0xFFFFFFFE
      run_op(4'b0010, 6'b011000, 32'd3, 32'hFFFF_FFFE, 0, 1'b0, 1'b0);
      // backpressure with a dropped request pulse
      run_op(4'b0010, 6'b100011, 32'd100, 32'd58, 5, 1'b1, 1'b0);
      // reset part way through an operation, then a normal addu
      reset_mid(4'b0010, 6'b011000, 32'd1234, 32'd5678, MUL_ITER ? 10 : 1);
      run_op(4'b0010, 6'b100001, 32'h1000_0001, 32'h0000_00FF, 0, 1'b0, 1'b0);
      // unmapped aluop
      run_op(4'b1111, 6'b100001, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         logic [3:0]    op;
         logic [5:0]    fn;
         logic [DW-1:0] a, b;
         case ($urandom_range(0, 3))
            0: begin op = 4'b0010; fn = RFN[$urandom_range(0, 7)]; end
            1: begin op = RAO[$urandom_range(0, 5)]; fn = 6'($urandom); end
            2: begin op = 4'($urandom); fn = 6'($urandom); end
            default: begin op = 4'b0010; fn = 6'($urandom); end
         endcase
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 3) == 0) begin a = a & 32'hFF; b = b & 32'h1F; end
         run_op(op, fn, a, b, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
